// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch/issue front end.
package ifu_pkg;

    // Fetch-side FSM state encoding
    typedef logic [1:0] ifu_state_e;
    localparam ifu_state_e IFU_IDLE = 2'd0;
    localparam ifu_state_e IFU_REQ  = 2'd1;
    localparam ifu_state_e IFU_WAIT = 2'd2;

    localparam logic [31:0] IFU_PC_INC   = 32'd4;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ifu_entry_t;

    function automatic logic [31:0] ifu_align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush; pointers carry one extra wrap bit.
module ifu_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // Push into a full FIFO is only allowed when the head leaves in the same cycle
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ifu_issue.sv
// Fetch/issue front end: owns the PC, fetches one word at a time and issues {pc, ir} packets.
module ifu_issue
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redir_vld_i,
    input  logic [31:0] redir_pc_i,
    output logic        imem_req_vld_o,
    input  logic        imem_req_rdy_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_vld_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        iexec_req_vld_o,
    input  logic        iexec_req_rdy_i,
    output logic [31:0] iexec_req_pc_o,
    output logic [31:0] iexec_req_ir_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 2;

    ifu_state_e  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;

    logic        req_hsk, rsp_take, push, pop;
    logic        fifo_empty, fifo_full;
    logic [AW:0] fifo_count;
    logic [CW-1:0] occ_now, occ_next;
    ifu_entry_t  push_entry, head_entry;

    assign imem_req_vld_o  = !rst_i && (state_q == IFU_REQ);
    assign imem_req_addr_o = fetch_pc_q;
    assign iexec_req_vld_o = !rst_i && !fifo_empty;
    assign iexec_req_pc_o  = head_entry.pc;
    assign iexec_req_ir_o  = head_entry.ir;

    assign req_hsk  = imem_req_vld_o && imem_req_rdy_i;
    assign rsp_take = imem_rsp_vld_i && outstanding_q;
    // Redirect voids both the push of a returning word and any issue handshake
    assign push     = rsp_take && !discard_q && !redir_vld_i;
    assign pop      = iexec_req_vld_o && iexec_req_rdy_i && !redir_vld_i;

    assign push_entry = '{pc: req_pc_q, ir: imem_rsp_data_i};
    assign occ_now    = CW'(fifo_count) + CW'(outstanding_q);
    assign occ_next   = CW'(fifo_count) + CW'(push) - CW'(pop);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redir_vld_i) begin
            fetch_pc_d = ifu_align_pc(redir_pc_i);
            // A fetch still in flight after this edge must have its response dropped
            if (req_hsk || (outstanding_q && !imem_rsp_vld_i)) begin
                state_d       = IFU_WAIT;
                outstanding_d = 1'b1;
                discard_d     = 1'b1;
            end else begin
                state_d       = IFU_REQ;
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
        end else begin
            case (state_q)
                IFU_IDLE: begin
                    if (occ_now < CW'(FIFO_DEPTH)) state_d = IFU_REQ;
                end
                IFU_REQ: begin
                    if (req_hsk) begin
                        state_d       = IFU_WAIT;
                        req_pc_d      = fetch_pc_q;
                        fetch_pc_d    = fetch_pc_q + IFU_PC_INC;
                        outstanding_d = 1'b1;
                    end
                end
                IFU_WAIT: begin
                    if (rsp_take) begin
                        outstanding_d = 1'b0;
                        discard_d     = 1'b0;
                        state_d       = (occ_next < CW'(FIFO_DEPTH)) ? IFU_REQ : IFU_IDLE;
                    end
                end
                default: state_d = IFU_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IFU_IDLE;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ifu_entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redir_vld_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifndef SYNTHESIS
    rsp_without_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rsp_vld_i |-> outstanding_q)
        else $error("imem response with no outstanding fetch");

    unused_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_full |-> !push || pop);
`endif

endmodule
